stream_sum_fixture: RTL and testbench
=====================================

Name: stream_sum_fixture

Overview:
- Verilator harness fixture that exercises valid/ready handshakes on both sides of a stage.
- Buffers 32-bit input beats in a small FIFO and accumulates them into per-packet sums.
- Presents one result per packet (sum, beat count, overflow) on a held-until-accepted output.
- Sits alongside the existing combinational/counter fixtures; the harness drives the input stream and consumes the result stream.

Parameters:
- WIDTH, 32, data and sum width in bits.
- DEPTH, 4, input FIFO entries; power of two, at least 2.
- CNT_W, 8, width of the beat-count and packet-count fields.

Ports:
- clk  input  1  rising-edge clock.
- sync_rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  fixture can accept a beat.
- in_data  input  WIDTH  beat payload.
- in_last  input  1  beat ends the current packet.
- out_valid  output  1  result pending.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH  packet sum, mod 2^WIDTH.
- out_beats  output  CNT_W  beats in the packet, saturating.
- out_overflow  output  1  a carry out of WIDTH occurred during the packet.
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- packets_done  output  CNT_W  results accepted downstream, wrapping.

Behaviour:
- Reset (sync_rst_n=0 at a rising edge):
  - FIFO is emptied, accumulator cleared, state returns to ACCUM.
  - out_valid, out_sum, out_beats, out_overflow, fifo_level and packets_done all read 0 after the edge.
  - in_ready is 0 while sync_rst_n=0 and 1 after reset deasserts.
  - Reset mid-packet or with a result pending discards everything; the abandoned result is never presented.
- Input handshake:
  - A beat {in_data, in_last} is pushed when in_valid && in_ready at a rising edge.
  - in_ready = !full and depends only on registered state (no combinational path from out_ready).
  - When full, no push occurs even if a pop happens in the same cycle.
  - in_valid with in_ready=0 has no effect.
- FIFO:
  - Registered storage; push and pop may occur in the same edge when neither full nor empty.
  - fifo_level is updated at that edge (+1, -1 or unchanged).
- State machine:
  - ACCUM:
    - If the FIFO is non-empty, pop one beat per edge.
    - acc <= acc + data, truncated to WIDTH.
    - ovf <= ovf | carry.
    - beats <= beats + 1, saturating at 2^CNT_W-1.
    - If the popped beat has last=1, then on the same edge load out_sum, out_beats and out_overflow with the updated values, clear acc, beats and ovf, set out_valid=1, and go to EMIT.
  - EMIT:
    - No pops; the FIFO still accepts pushes until full.
    - out_* are held stable while out_valid=1.
    - On out_valid && out_ready at an edge: out_valid <= 0, packets_done <= packets_done + 1 (wraps), go to ACCUM.
    - Popping resumes on the next edge; no pop occurs in the handoff edge.
- Latency: last beat pushed at edge E into an empty FIFO in ACCUM → popped at edge E+1 → out_valid=1 after E+1.
- Throughput: at most one packet result per 2 cycles. A single-beat packet stream sustains 1 result per 2 edges when out_ready is held at 1.
- out_ready while out_valid=0 is ignored.
- The zero-beat packet is impossible; every packet contains at least its last beat.
- out_sum, out_beats and out_overflow keep their last value after acceptance; only out_valid qualifies them.

Test Plan:
- Reset, then push 3 beats 1, 2, 3 (last on the 3rd) with out_ready=1 → one result: out_sum=6, out_beats=3, out_overflow=0; packets_done=1.
- Push 0xFFFFFFFF then 0x00000002 (last) → out_sum=0x00000001, out_overflow=1; the next packet of 5 (last) gives out_sum=5, out_overflow=0.
- out_ready=0, continuous single-beat packets of value k=1..8 → first result (sum 1) held; FIFO fills to fifo_level=4 with in_ready=0. Then release out_ready=1 → results 1..8 emerge in order; packets_done=8.
- 300-beat packet of value 1 → out_sum=300, out_beats=255 (saturated).
- Drive sync_rst_n=0 for one edge while a result is pending and 2 beats are buffered → next cycle out_valid=0, fifo_level=0, packets_done=0; a new 1-beat packet of 7 yields out_sum=7.
- Latency check: last beat accepted at edge E into an empty FIFO → out_valid observed high after edge E+1, not earlier.

Source files
------------

// File: rtl/stream_sum_fixture.sv
// Stream-sum fixture: buffers input beats in a small FIFO, sums each packet,
// and presents one held-until-accepted result per packet.
module stream_sum_fixture #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     sync_rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic [CNT_W-1:0]         out_beats,
  output logic                     out_overflow,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         packets_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {ACCUM, EMIT} state_t;

  logic [WIDTH:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [CNT_W-1:0]   beats;
  logic               ovf;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [WIDTH:0]     head;
  logic [WIDTH:0]     sum_ext;
  logic [CNT_W-1:0]   beats_inc;

  // in_ready comes only from registered occupancy (and reset), never from out_ready
  assign full      = (fifo_level == LVL_W'(DEPTH));
  assign empty     = (fifo_level == '0);
  assign in_ready  = sync_rst_n && !full;
  assign push      = in_valid && in_ready;
  assign pop       = (state == ACCUM) && !empty;
  assign head      = mem_q[rd_ptr];
  assign sum_ext   = {1'b0, acc} + {1'b0, head[WIDTH-1:0]};
  assign beats_inc = (beats == '1) ? beats : beats + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr] <= {in_last, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      state        <= ACCUM;
      acc          <= '0;
      beats        <= '0;
      ovf          <= 1'b0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_beats    <= '0;
      out_overflow <= 1'b0;
      packets_done <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop);

      case (state)
        ACCUM: begin
          if (pop) begin
            // The last beat publishes the updated totals and restarts the accumulator
            if (head[WIDTH]) begin
              out_sum      <= sum_ext[WIDTH-1:0];
              out_beats    <= beats_inc;
              out_overflow <= ovf | sum_ext[WIDTH];
              out_valid    <= 1'b1;
              acc          <= '0;
              beats        <= '0;
              ovf          <= 1'b0;
              state        <= EMIT;
            end else begin
              acc   <= sum_ext[WIDTH-1:0];
              beats <= beats_inc;
              ovf   <= ovf | sum_ext[WIDTH];
            end
          end
        end
        EMIT: begin
          if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
            packets_done <= packets_done + CNT_W'(1);
            state        <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_sum_fixture.sv
// Self-checking bench for stream_sum_fixture: directed scenarios plus random
// traffic, checked against a packet-level arithmetic model.
module tb_stream_sum_fixture;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic [CNT_W-1:0] beats;
    logic             ovf;
  } result_t;

  logic             clk = 1'b0;
  logic             sync_rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [CNT_W-1:0] out_beats;
  logic             out_overflow;
  logic [LVL_W-1:0] fifo_level;
  logic [CNT_W-1:0] packets_done;

  int checks = 0;
  int fails  = 0;
  int accepted = 0;
  int cyc;

  logic [WIDTH-1:0] pkt[$];
  logic [WIDTH:0]   beat_q[$];
  result_t          exp_q[$];

  always #5 clk = ~clk;

  stream_sum_fixture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .sync_rst_n   (sync_rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_beats    (out_beats),
    .out_overflow (out_overflow),
    .fifo_level   (fifo_level),
    .packets_done (packets_done)
  );

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: a packet's result is plain 64-bit arithmetic over its beats
  task automatic commit_packet();
    longint unsigned total = 0;
    result_t r;
    foreach (pkt[i]) begin
      total += 64'(pkt[i]);
      beat_q.push_back({(i == pkt.size() - 1), pkt[i]});
    end
    r.sum   = total[WIDTH-1:0];
    r.beats = (pkt.size() > 255) ? 8'd255 : CNT_W'(pkt.size());
    r.ovf   = (total >= 64'h1_0000_0000);
    exp_q.push_back(r);
    pkt.delete();
  endtask

  // One clock: drive, note handshakes, check accepted result and held outputs
  task automatic apply_stimulus(input bit valid_en, input bit ready);
    bit fire_in;
    bit fire_out;
    bit stall;
    logic [WIDTH+CNT_W+1:0] held;
    result_t r;
    in_valid = valid_en && (beat_q.size() > 0);
    if (in_valid) {in_last, in_data} = beat_q[0];
    else begin
      in_data = $urandom;
      in_last = 1'b0;
    end
    out_ready = ready;
    #1;
    fire_in  = in_valid && in_ready;
    fire_out = out_valid && out_ready;
    stall    = out_valid && !out_ready;
    held     = {out_valid, out_sum, out_beats, out_overflow};
    if (fire_out) begin
      if (exp_q.size() == 0) check_output("unexpected_result", 1, 0);
      else begin
        r = exp_q.pop_front();
        check_output("out_sum", out_sum, r.sum);
        check_output("out_beats", out_beats, r.beats);
        check_output("out_overflow", out_overflow, r.ovf);
        accepted++;
      end
    end
    @(posedge clk);
    #1;
    if (fire_in) void'(beat_q.pop_front());
    check_output("packets_done", packets_done, CNT_W'(accepted));
    if (stall) check_output("held_result", {out_valid, out_sum, out_beats, out_overflow}, held);
  endtask

  task automatic drain(input int limit, input bit random_mode, output int cycles);
    cycles = 0;
    while ((beat_q.size() > 0 || exp_q.size() > 0) && cycles < limit) begin
      if (random_mode) apply_stimulus(($urandom_range(3) != 0), $urandom_range(1) == 1);
      else apply_stimulus(1'b1, 1'b1);
      cycles++;
    end
    if (cycles >= limit) check_output("drain_timeout", 1, 0);
  endtask

  task automatic do_reset();
    sync_rst_n = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    @(posedge clk);
    #1;
    check_output("rst_in_ready_low", in_ready, 0);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_out_sum", out_sum, 0);
    check_output("rst_out_beats", out_beats, 0);
    check_output("rst_out_overflow", out_overflow, 0);
    check_output("rst_fifo_level", fifo_level, 0);
    check_output("rst_packets_done", packets_done, 0);
    sync_rst_n = 1'b1;
    beat_q.delete();
    exp_q.delete();
    accepted = 0;
    #1;
    check_output("rst_in_ready_high", in_ready, 1);
  endtask

  initial begin
    do_reset();

    // Simple 3-beat packet
    pkt = '{32'd1, 32'd2, 32'd3};
    commit_packet();
    drain(100, 1'b0, cyc);
    check_output("pkts_after_first", packets_done, 1);

    // Carry out of WIDTH, then a clean packet
    pkt = '{32'hFFFF_FFFF, 32'h0000_0002};
    commit_packet();
    pkt = '{32'd5};
    commit_packet();
    drain(100, 1'b0, cyc);

    // Backpressure: first result held, FIFO fills
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      pkt = '{k};
      commit_packet();
    end
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b0);
    check_output("bp_out_valid", out_valid, 1);
    check_output("bp_out_sum", out_sum, 1);
    check_output("bp_fifo_level", fifo_level, DEPTH);
    check_output("bp_in_ready", in_ready, 0);
    drain(200, 1'b0, cyc);
    check_output("bp_packets_done", packets_done, 8);

    // Long packet saturates the beat count
    for (int i = 0; i < 300; i++) pkt.push_back(32'd1);
    commit_packet();
    drain(2000, 1'b1, cyc);

    // Latency: last beat pushed at E into an empty FIFO, result after E+1
    pkt = '{32'd42};
    commit_packet();
    apply_stimulus(1'b1, 1'b0);
    check_output("lat_not_early", out_valid, 0);
    check_output("lat_level", fifo_level, 1);
    apply_stimulus(1'b1, 1'b0);
    check_output("lat_valid", out_valid, 1);
    check_output("lat_sum", out_sum, 42);
    drain(100, 1'b0, cyc);

    // Throughput: single-beat packets, one result per two edges
    for (int k = 0; k < 6; k++) begin
      pkt = '{32'(100 + k)};
      commit_packet();
    end
    drain(100, 1'b0, cyc);
    check_output("throughput_cycles", cyc, 13);

    // Reset with a pending result and two buffered beats
    for (int k = 9; k <= 11; k++) begin
      pkt = '{k};
      commit_packet();
    end
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0);
    check_output("pre_rst_valid", out_valid, 1);
    check_output("pre_rst_level", fifo_level, 2);
    do_reset();
    pkt = '{32'd7};
    commit_packet();
    drain(100, 1'b0, cyc);
    check_output("post_rst_packets", packets_done, 1);

    // Random traffic
    for (int p = 0; p < 40; p++) begin
      int n = $urandom_range(6, 1);
      for (int i = 0; i < n; i++)
        pkt.push_back(($urandom_range(1) == 1) ? 32'($urandom) : 32'($urandom_range(1000)));
      commit_packet();
    end
    drain(5000, 1'b1, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
